// File: rtl/l2_request_arbiter_if.sv
// L1-to-L2 request bundle for the two-port L2 request arbiter.
// master = L1 caches and L2 controller side, slave = arbiter side.
interface l2_request_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
   );

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
      output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
   );
endinterface

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line requests onto one L2 port.
// The winning request is latched and held toward L2 until l2_resp.
module l2_request_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input logic                 clk,
   input logic                 rst_n,
   l2_request_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              grant_i, grant_d;
   logic              i_req, d_req;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the port that did not win last time gets the grant
            if (i_req && d_req) begin
               grant_i = last_grant;
               grant_d = ~last_grant;
            end else begin
               grant_i = i_req;
               grant_d = d_req;
            end
            if (grant_i)      state_nxt = SERVE_I;
            else if (grant_d) state_nxt = SERVE_D;
         end
         SERVE_I: if (bus.l2_resp) state_nxt = IDLE;
         SERVE_D: if (bus.l2_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_write   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_i) begin
            addr_q     <= bus.i_addr;
            op_write   <= 1'b0;
            last_grant <= 1'b0;
         end else if (grant_d) begin
            addr_q     <= bus.d_addr;
            wdata_q    <= bus.d_wdata;
            op_write   <= bus.d_write;
            last_grant <= 1'b1;
         end
      end
   end

   assign bus.l2_read  = (state != IDLE) & ~op_write;
   assign bus.l2_write = (state != IDLE) & op_write;
   assign bus.l2_addr  = addr_q;
   assign bus.l2_wdata = wdata_q;

   assign bus.i_resp  = (state == SERVE_I) & bus.l2_resp;
   assign bus.d_resp  = (state == SERVE_D) & bus.l2_resp;
   assign bus.i_rdata = bus.l2_rdata;
   assign bus.d_rdata = bus.l2_rdata;

endmodule
